// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with a one-byte holding register.
// The serial line is synchronised, each bit is sampled at its centre, and
// completed bytes are offered on a valid/ready handshake. Framing errors and
// overruns are reported as single-cycle pulses.
module uart_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  // Centre sampling needs enough clocks per bit to be meaningful.
  if (CLKS_PER_BIT < 8) begin : g_bad_baud
    $error("uart_rx: CLK_HZ/BAUD must be at least 8");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          rx_meta, rx_s;
  logic          deliver;
  logic          ferr_d;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // FSM and bit-timing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      sh_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
    end
  end

  // Next-state logic: half-bit check of the start bit, then one sample per
  // bit period so every data and stop sample lands near the bit centre.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    sh_d      = sh_q;
    deliver   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line that is high again at mid-start was only a glitch.
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          sh_d      = {rx_s, sh_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            sh_d    = '0;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line idles so a break is not read as starts.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register, handshake and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr_d;
      overrun   <= 1'b0;
      if (deliver && (!data_valid || data_ready)) begin
        data_out   <= sh_q;
        data_valid <= 1'b1;
      end else begin
        if (deliver) overrun <= 1'b1;
        if (data_valid && data_ready) data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at the default 50 MHz / 115200 settings.
// Stimulus pushes expected bytes into a queue; a monitor pops and compares
// on every accepted handshake and tallies error pulses.
module tb_uart_rx;

  localparam int CPB  = 434;
  localparam int HALF = 217;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLK_HZ(50000000), .BAUD(115200)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Advance n clocks and land just after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame at cpb clocks per bit; the line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_bit);
    rx_in = 1'b0;
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(cpb);
    end
    rx_in = stop_bit;
    tick(cpb);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %0h expected none", data_out);
        end else begin
          chk("rx_byte", data_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst        = 1'b1;
    rx_in      = 1'b1;
    data_ready = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(1);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flags", {frame_err, overrun}, 2'b00);
    tick(10);

    // 1: 0x55 with ready held, latency and single-cycle valid
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, CPB, 1'b1);
      begin
        lat = 0;
        while (!data_valid && lat < 5000) begin
          tick(1);
          lat++;
        end
        chk_rng("t1_latency", lat, 4124, 4128);
        tick(1);
        chk("t1_valid_one_cycle", data_valid, 1'b0);
      end
    join
    tick(20);
    chk("t1_no_ferr", ferr_cnt, 0);
    chk("t1_no_ovr", ovr_cnt, 0);

    // 2: overrun with consumer stalled, then a single-cycle accept
    data_ready = 1'b0;
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, CPB, 1'b1);
    send_frame(8'h3C, CPB, 1'b1);
    tick(20);
    chk("t2_ovr_once", ovr_cnt, 1);
    chk("t2_held_byte", data_out, 8'hA3);
    chk("t2_held_valid", data_valid, 1'b1);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    tick(1);
    chk("t2_valid_cleared", data_valid, 1'b0);
    chk("t2_data_kept", data_out, 8'hA3);
    data_ready = 1'b1;
    tick(20);

    // 3: framing error followed by a long break, then recovery
    send_frame(8'h7E, CPB, 1'b0);
    tick(2000);
    chk("t3_busy_in_break", busy, 1'b1);
    rx_in = 1'b1;
    tick(4);
    chk("t3_busy_released", busy, 1'b0);
    chk("t3_ferr_once", ferr_cnt, 1);
    tick(50);
    exp_q.push_back(8'h31);
    send_frame(8'h31, CPB, 1'b1);
    tick(20);

    // 4: short low glitch on an idle line
    rx_in = 1'b0;
    fork
      begin
        tick(100);
        rx_in = 1'b1;
      end
      begin
        lat = 0;
        while ((lat < 5 || busy) && lat < 1000) begin
          tick(1);
          lat++;
        end
        chk_rng("t4_glitch_busy_len", lat, HALF, HALF + 5);
      end
    join
    tick(20);
    chk("t4_no_ferr", ferr_cnt, 1);

    // 5: reset during bit 4 of 0xFF aborts the frame
    rx_in = 1'b0;
    tick(CPB);
    rx_in = 1'b1;
    tick(4 * CPB + 200);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_rst_data_out", data_out, 8'h00);
    chk("t5_rst_valid", data_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_flags", {frame_err, overrun}, 2'b00);
    tick(5 * CPB);
    exp_q.push_back(8'hC4);
    send_frame(8'hC4, CPB, 1'b1);
    tick(20);

    // 6: baud mismatch of about +2% and -2%
    exp_q.push_back(8'h96);
    send_frame(8'h96, 425, 1'b1);
    tick(20);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 443, 1'b1);
    tick(20);
    chk("t6_no_ferr", ferr_cnt, 1);
    chk("t6_no_ovr", ovr_cnt, 1);

    chk("all_bytes_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, LSB first, for the FPGA top level. It receives bytes from the host USB-UART on uart_txd_in and feeds them into the design.
- Pairs with the design's UART transmitter on uo_out[3]. Intended use: a host-side loader/console path into the DuckCPU.
- Output is a one-byte holding register with a valid/ready handshake. Framing errors and overruns are flagged.

Parameters:
- CLK_HZ, 50000000, frequency of clk in Hz (clk_50mhz at the top level).
- BAUD, 115200, line rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (434), derived localparam, integer-truncated. Must be >= 8, otherwise elaboration error.
- HALF_BIT, CLKS_PER_BIT/2 (217), derived localparam.

Ports:
- clk  in  1  system clock; the top level connects clk_50mhz.
- rst  in  1  synchronous, active-high reset. The top level drives it as ~rst_n.
- rx_in  in  1  asynchronous serial line, idle high.
- data_out  out  8  received byte; stable while data_valid=1.
- data_valid  out  1  a byte is held in data_out.
- data_ready  in  1  consumer accepts the byte on a cycle where data_valid and data_ready are both 1.
- frame_err  out  1  one-cycle pulse: the stop bit was sampled 0.
- overrun  out  1  one-cycle pulse: a good byte completed while the holding register was full and not being accepted.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Synchronizer: rx_in passes through 2 flops, both reset to 1. Only the synchronized value rx_s is used afterwards.
- Bit timer cnt has width $clog2(CLKS_PER_BIT). bit_idx is 3 bits. Shift register sh is 8 bits and shifts right, with the new bit entering at bit 7.
- State machine:
  - IDLE: cnt=0. If rx_s==0, go to START.
  - START: cnt counts up. At cnt==HALF_BIT-1, re-sample rx_s. If 0, go to DATA with cnt=0 and bit_idx=0. If 1, treat it as a glitch: go to IDLE with no output.
  - DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into sh, reset cnt to 0, increment bit_idx. After bit_idx==7 is sampled, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - If rx_s==1, deliver the byte and go to IDLE.
    - If rx_s==0, pulse frame_err for one cycle, discard sh, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition from being seen as repeated start bits.
- Delivery, in the cycle the stop bit is sampled as 1:
  - If data_valid==0, or data_valid&&data_ready: load data_out<=sh. data_valid is 1 on the next cycle.
  - Otherwise: pulse overrun for one cycle. The new byte is dropped and the old data_out/data_valid are unchanged.
- Handshake:
  - data_valid&&data_ready clears data_valid on the next cycle, unless a delivery in that same cycle reloads it. In that case data_valid stays 1 and data_out takes the new byte.
  - data_ready while data_valid==0 has no effect.
- Latency:
  - The falling edge at rx_in reaches rx_s after 2 cycles.
  - data_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles (±1) after the edge, i.e. about 4126 cycles at the defaults.
  - The next start bit is accepted from the first cycle back in IDLE, so back-to-back frames with no idle time are received.
- Reset:
  - Outputs after reset: data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0. Internally state=IDLE and cnt, bit_idx, sh all 0.
  - Reset asserted mid-frame aborts the frame. The partial byte is never delivered.
  - After reset, a line that is already low is treated as a start bit.
- Timing tolerance: sampling at bit centre tolerates ±4% baud mismatch over a 10-bit frame.

Test Plan:
- Reset, then send 0x55 at 115200 with data_ready=1 held → data_out=0x55 and data_valid high for exactly 1 cycle, about 4126 cycles after the start edge. frame_err=0, overrun=0.
- data_ready=0, send 0xA3 then 0x3C back-to-back → data_out=0xA3 held. overrun pulses once at the end of the 0x3C frame. Raise data_ready for 1 cycle → data_valid falls next cycle and data_out stays 0xA3.
- Send 0x7E with the stop bit forced to 0, hold the line low for 2000 cycles, then release → exactly one frame_err pulse, no data_valid, busy=1 until the line goes high. A following 0x31 is received correctly.
- Low glitch of 100 cycles on an idle line → no data_valid and no frame_err; busy returns to 0 at about HALF_BIT+2 cycles after the edge.
- Assert rst for 1 cycle during bit 4 of 0xFF → all outputs 0 the next cycle, no delivery. A following 0xC4 is received correctly.
- Send 0x96 at BAUD+2% and at BAUD-2% → data_out=0x96 in both cases, with no error flags.
